// File: rtl/vpe_dot_pe_acc.sv
`default_nettype none
// ============================================================================
// Module      : vpe_dot_pe_acc
// Description : Pipelined fixed-point dot-product processing element with
//               optional accumulation across beats.
//               Stage 0 captures the data beat and a snapshot of the weight
//               register. Stage 1 forms full-width lane products. Stage 2
//               truncates and saturates each product to DW bits. The stages
//               after that form a registered pairwise adder tree that clamps
//               at every node. The final stage either emits the tree sum or
//               folds it into a saturating accumulator.
//               Latency from a beat's sampling edge to o_data_v is
//               3 + log2(LANES) cycles.
// Ports       : clk, rst_n           - clock, async active-low reset
//               i_data / i_data_v    - LANES x DW data vector and its valid
//               i_weight / i_weight_v- LANES x DW weight vector and load strobe
//               i_acc_en / i_last    - accumulate mode and final-beat marker
//               o_data / o_data_v    - DW result and single-cycle valid
//               o_sat                - saturation seen anywhere in the result
// Revision    : 1.0 - initial release
// ============================================================================
module vpe_dot_pe_acc #(
    parameter int LANES = 8,
    parameter int DW    = 8,
    parameter int FRAC  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LANES*DW-1:0]   i_data,
    input  logic                  i_data_v,
    input  logic [LANES*DW-1:0]   i_weight,
    input  logic                  i_weight_v,
    input  logic                  i_acc_en,
    input  logic                  i_last,
    output logic [DW-1:0]         o_data,
    output logic                  o_data_v,
    output logic                  o_sat
);

    localparam int c_LOG2_LANES = $clog2(LANES);
    // Heap-ordered tree: node 0 is the root, leaves sit at LANES-1 .. 2*LANES-2
    localparam int c_NODES      = 2 * LANES - 1;
    // Flag stages 0 .. 2+log2(LANES); the last one travels alongside the root
    localparam int c_FSTAGES    = c_LOG2_LANES + 3;
    localparam logic [DW-1:0] c_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] c_MIN = {1'b1, {(DW-1){1'b0}}};

    // Per-beat flags: bit 0 valid, bit 1 acc_en, bit 2 last
    logic [2:0]            r_flags [c_FSTAGES];
    logic [LANES*DW-1:0]   r_weight;
    logic [LANES*DW-1:0]   r_data0;
    logic [LANES*DW-1:0]   r_weight0;
    logic [2*DW-1:0]       r_prod   [LANES];
    logic [2*DW-1:0]       w_prod_d [LANES];
    logic [DW-1:0]         r_tree   [c_NODES];
    logic [DW-1:0]         w_tree_d [c_NODES];
    logic [c_NODES-1:0]    r_tsat;
    logic [c_NODES-1:0]    w_tsat_d;
    logic [DW-1:0]         r_acc;
    logic                  r_sticky;

    // ------------------------------------------------------------------
    // Control path: weight register and flag pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_weight <= '0;
            for (int s = 0; s < c_FSTAGES; s++) begin
                r_flags[s] <= '0;
            end
        end else begin
            if (i_weight_v) begin
                r_weight <= i_weight;
            end
            r_flags[0] <= {i_last, i_acc_en, i_data_v};
            for (int s = 1; s < c_FSTAGES; s++) begin
                r_flags[s] <= r_flags[s-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers: free-running, qualified by the flag pipeline.
    // The weight snapshot is taken from r_weight as it stands before the
    // edge, so a load coinciding with a beat only affects later beats.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        r_data0   <= i_data;
        r_weight0 <= r_weight;
        r_prod    <= w_prod_d;
        r_tree    <= w_tree_d;
        r_tsat    <= w_tsat_d;
    end

    // ------------------------------------------------------------------
    // Stage 1 products and stage 2 quantisation, one slice per lane
    // ------------------------------------------------------------------
    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            logic [DW-1:0]     w_d;
            logic [DW-1:0]     w_w;
            logic [DW-FRAC:0]  w_hi;
            logic              w_ovf;
            logic              w_unused_prod;

            assign w_d = r_data0[k*DW +: DW];
            assign w_w = r_weight0[k*DW +: DW];
            // Sign-extend both operands so the low 2*DW bits are the signed product
            assign w_prod_d[k] = {{DW{w_d[DW-1]}}, w_d} * {{DW{w_w[DW-1]}}, w_w};

            // Bits from FRAC+DW-1 upward must all agree for the result to fit
            assign w_hi  = r_prod[k][2*DW-1:FRAC+DW-1];
            assign w_ovf = ~((&w_hi) | ~(|w_hi));
            assign w_tree_d[LANES-1+k] = w_ovf ? (r_prod[k][2*DW-1] ? c_MIN : c_MAX)
                                               : r_prod[k][FRAC+DW-1:FRAC];
            assign w_tsat_d[LANES-1+k] = w_ovf;
            // The low FRAC bits are discarded by truncation
            assign w_unused_prod = ^r_prod[k];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Adder tree: each internal node adds its two children at DW+1 bits
    // and clamps. Node i has children 2i+1 (even lane side) and 2i+2.
    // ------------------------------------------------------------------
    genvar n;
    generate
        for (n = 0; n < LANES - 1; n++) begin : g_node
            logic [DW:0] w_sum;
            logic        w_clamp;

            assign w_sum   = {r_tree[2*n+1][DW-1], r_tree[2*n+1]}
                           + {r_tree[2*n+2][DW-1], r_tree[2*n+2]};
            assign w_clamp = w_sum[DW] ^ w_sum[DW-1];
            assign w_tree_d[n] = w_clamp ? (w_sum[DW] ? c_MIN : c_MAX) : w_sum[DW-1:0];
            assign w_tsat_d[n] = r_tsat[2*n+1] | r_tsat[2*n+2] | w_clamp;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Accumulator / output stage
    // ------------------------------------------------------------------
    logic [2:0]    w_fl;
    logic [DW:0]   w_acc_sum;
    logic          w_acc_clamp;
    logic [DW-1:0] w_acc_res;

    assign w_fl        = r_flags[c_FSTAGES-1];
    assign w_acc_sum   = {r_acc[DW-1], r_acc} + {r_tree[0][DW-1], r_tree[0]};
    assign w_acc_clamp = w_acc_sum[DW] ^ w_acc_sum[DW-1];
    assign w_acc_res   = w_acc_clamp ? (w_acc_sum[DW] ? c_MIN : c_MAX) : w_acc_sum[DW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_sticky <= 1'b0;
            o_data   <= '0;
            o_data_v <= 1'b0;
            o_sat    <= 1'b0;
        end else begin
            o_data_v <= 1'b0;
            if (w_fl[0]) begin
                if (!w_fl[1]) begin
                    // Single-beat dot: pass the tree result, accumulator untouched
                    o_data   <= r_tree[0];
                    o_sat    <= r_tsat[0];
                    o_data_v <= 1'b1;
                end else if (!w_fl[2]) begin
                    r_acc    <= w_acc_res;
                    r_sticky <= r_sticky | r_tsat[0] | w_acc_clamp;
                end else begin
                    o_data   <= w_acc_res;
                    o_sat    <= r_sticky | r_tsat[0] | w_acc_clamp;
                    o_data_v <= 1'b1;
                    r_acc    <= '0;
                    r_sticky <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vpe_dot_pe_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_vpe_dot_pe_acc
// Description : Scoreboard bench for vpe_dot_pe_acc (LANES=8, DW=8, FRAC=5).
//               Stimulus pushes the hand-computed result and the cycle it is
//               due; a monitor pops and compares whenever o_data_v is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vpe_dot_pe_acc;

    localparam int LANES = 8;
    localparam int DW    = 8;
    localparam int FRAC  = 5;
    localparam int LAT   = 6;

    logic                clk;
    logic                rst_n;
    logic [LANES*DW-1:0] i_data;
    logic                i_data_v;
    logic [LANES*DW-1:0] i_weight;
    logic                i_weight_v;
    logic                i_acc_en;
    logic                i_last;
    logic [DW-1:0]       o_data;
    logic                o_data_v;
    logic                o_sat;

    vpe_dot_pe_acc #(.LANES(LANES), .DW(DW), .FRAC(FRAC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data     (i_data),
        .i_data_v   (i_data_v),
        .i_weight   (i_weight),
        .i_weight_v (i_weight_v),
        .i_acc_en   (i_acc_en),
        .i_last     (i_last),
        .o_data     (o_data),
        .o_data_v   (o_data_v),
        .o_sat      (o_sat)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          sat;
        int            cyc;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LANES*DW-1:0] splat(input logic [DW-1:0] v);
        return {LANES{v}};
    endfunction

    task automatic check(input string name, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // One input cycle. If expv is set, the result it should produce is queued
    // together with the monitor cycle at which it is due.
    task automatic beat(input logic [LANES*DW-1:0] d, input logic [LANES*DW-1:0] w,
                        input logic wv, input logic dv, input logic acc, input logic last,
                        input logic expv, input logic [DW-1:0] ed, input logic es);
        exp_t e;
        @(negedge clk);
        i_data     = d;
        i_weight   = w;
        i_weight_v = wv;
        i_data_v   = dv;
        i_acc_en   = acc;
        i_last     = last;
        if (expv) begin
            e.data = ed;
            e.sat  = es;
            e.cyc  = cyc + LAT + 1;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_data_v   = 1'b0;
            i_weight_v = 1'b0;
            i_acc_en   = 1'b0;
            i_last     = 1'b0;
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_n && o_data_v) begin
            if (q.size() == 0) begin
                n_cmp  <= n_cmp + 1;
                n_fail <= n_fail + 1;
                $display("FAIL unexpected_output: got data=%0h sat=%0b, required no output",
                         o_data, o_sat);
            end else begin
                m_e = q.pop_front();
                check("result_data", int'(o_data), int'(m_e.data));
                check("result_sat", int'(o_sat), int'(m_e.sat));
                check("result_cycle", cyc, m_e.cyc);
            end
        end
    end

    logic [LANES*DW-1:0] mixed;

    initial begin
        rst_n      = 1'b1;
        i_data     = '0;
        i_data_v   = 1'b0;
        i_weight   = '0;
        i_weight_v = 1'b0;
        i_acc_en   = 1'b0;
        i_last     = 1'b0;
        for (int k = 0; k < LANES; k++) mixed[k*DW +: DW] = 8'(k - 4);

        // Asynchronous reset: outputs clear without a clock edge
        #3 rst_n = 1'b0;
        #1;
        check("reset_o_data", int'(o_data), 0);
        check("reset_o_data_v", int'(o_data_v), 0);
        check("reset_o_sat", int'(o_sat), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Weights 16, data 16: each lane 256>>5 = 8, sum 64
        beat('0, splat(8'd16), 1, 0, 0, 0, 0, '0, 0);
        beat(splat(8'd16), '0, 0, 1, 0, 0, 1, 8'd64, 0);
        idle(1);

        // Accumulated dot with idle gap: 3 x 32 = 96
        beat(splat(8'd8), '0, 0, 1, 1, 0, 0, '0, 0);
        idle(2);
        beat(splat(8'd8), '0, 0, 1, 1, 0, 0, '0, 0);
        beat(splat(8'd8), '0, 0, 1, 1, 1, 1, 8'd96, 0);
        idle(1);

        // Weights 32, data -32: lanes -32, tree clamps at the root to -128
        beat('0, splat(8'd32), 1, 0, 0, 0, 0, '0, 0);
        beat(splat(8'hE0), '0, 0, 1, 0, 0, 1, 8'h80, 1);
        idle(1);

        // 127 x 127: lane saturation to 127 plus tree clamp
        beat('0, splat(8'h7F), 1, 0, 0, 0, 0, '0, 0);
        beat(splat(8'h7F), '0, 0, 1, 0, 0, 1, 8'h7F, 1);
        idle(1);

        // Streaming, with a weight load coinciding with the first beat
        beat('0, splat(8'd16), 1, 0, 0, 0, 0, '0, 0);
        beat(splat(8'd8), splat(8'd32), 1, 1, 0, 0, 1, 8'd32, 0);  // old weights 16
        beat(splat(8'd8), '0, 0, 1, 0, 0, 1, 8'd64, 0);            // new weights 32
        beat(mixed, '0, 0, 1, 0, 0, 1, 8'hFC, 0);                   // -4..3 sums to -4
        beat(splat(8'hFF), '0, 0, 1, 0, 0, 1, 8'hF8, 0);            // -32>>5 = -1 per lane
        beat(splat(8'd12), '0, 0, 1, 1, 0, 0, '0, 0);               // 96
        beat(splat(8'd12), '0, 0, 1, 1, 1, 1, 8'h7F, 1);            // 192 clamps to 127
        beat(splat(8'd4), '0, 0, 1, 0, 1, 1, 8'd32, 0);             // last ignored
        idle(1);

        // Sticky saturation: -128 (tree sat) then +32 -> -96 with sat
        beat(splat(8'hE0), '0, 0, 1, 1, 0, 0, '0, 0);
        beat(splat(8'd4), '0, 0, 1, 1, 1, 1, 8'hA0, 1);
        idle(10);
        check("hold_o_data", int'(o_data), 'hA0);
        check("hold_o_sat", int'(o_sat), 1);

        beat(splat(8'd8), '0, 0, 1, 0, 0, 1, 8'd64, 0);
        idle(10);
        check("hold_o_data_2", int'(o_data), 64);
        check("hold_o_data_v", int'(o_data_v), 0);

        // Reset mid-accumulation with a single-beat dot also in flight
        beat(splat(8'd8), '0, 0, 1, 1, 0, 0, '0, 0);
        beat(splat(8'd8), '0, 0, 1, 1, 0, 0, '0, 0);
        beat(splat(8'd8), '0, 0, 1, 0, 0, 0, '0, 0);
        @(negedge clk);
        i_data_v = 1'b0;
        i_acc_en = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midreset_o_data", int'(o_data), 0);
        check("midreset_o_data_v", int'(o_data_v), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        // Weights were cleared by reset, so this dot is zero
        beat(splat(8'd8), '0, 0, 1, 0, 0, 1, 8'd0, 0);
        beat('0, splat(8'd32), 1, 0, 0, 0, 0, '0, 0);
        beat(splat(8'd8), '0, 0, 1, 0, 0, 1, 8'd64, 0);
        beat(splat(8'd8), '0, 0, 1, 1, 1, 1, 8'd64, 0);            // accumulator was cleared
        idle(12);

        check("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
